// File: rtl/cnn_layer_seq.sv
// Layer sequencer for a CNN accelerator: queues layer descriptors, validates and
// issues them one at a time, supervises busy/done with a timeout, reports completion.
module cnn_layer_seq #(
    parameter int          DEPTH   = 4,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [7:0]              cmd_width,
    input  logic [7:0]              cmd_height,
    input  logic [3:0]              cmd_in_ch,
    input  logic [3:0]              cmd_out_ch,
    input  logic [3:0]              cmd_stride,
    input  logic [3:0]              cmd_tag,
    input  logic                    run_en,
    input  logic                    abort,
    output logic                    acc_start_vld,
    output logic [7:0]              acc_width,
    output logic [7:0]              acc_height,
    output logic [3:0]              acc_in_ch,
    output logic [3:0]              acc_out_ch,
    output logic [3:0]              acc_stride,
    input  logic                    acc_busy,
    input  logic                    acc_done,
    input  logic [11:0]             acc_last_addr,
    output logic                    cpl_vld,
    input  logic                    cpl_rdy,
    output logic [3:0]              cpl_tag,
    output logic [11:0]             cpl_last_addr,
    output logic [1:0]              cpl_err,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    seq_idle
);

    // state       | meaning
    // S_IDLE      | waiting for run_en and a queued descriptor
    // S_ISSUE     | one-cycle start pulse to the accelerator
    // S_WAIT_BUSY | waiting for the accelerator to raise busy
    // S_WAIT_DONE | waiting for done
    // S_DRAIN     | timed out or aborted, waiting for busy to fall
    // S_REPORT    | completion record offered until accepted
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DRAIN, S_REPORT
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t            state, state_nxt;
    logic [31:0]       fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [19:0]       tcnt;

    logic [7:0]        h_width, h_height;
    logic [3:0]        h_in_ch, h_out_ch, h_stride, h_tag;
    logic              head_ok, push, pop, ld_cfg;
    logic              rep_bad, fin_ok, fin_to, fin_abort;

    assign {h_width, h_height, h_in_ch, h_out_ch, h_stride, h_tag} = fifo_mem[rd_ptr];

    assign head_ok = ((h_stride == 4'd1) || (h_stride == 4'd2)) &&
                     (h_in_ch  >= 4'd1) && (h_in_ch  <= 4'd8) &&
                     (h_out_ch >= 4'd1) && (h_out_ch <= 4'd8) &&
                     (h_width  >= 8'd3) && (h_height >= 8'd3);

    assign cmd_rdy       = (q_count < CW'(DEPTH)) && !rst;
    // a push coinciding with abort is discarded along with the flushed queue
    assign push          = cmd_vld && cmd_rdy && !abort;
    assign acc_start_vld = (state == S_ISSUE);
    assign seq_idle      = (state == S_IDLE) && (q_count == '0);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ld_cfg    = 1'b0;
        rep_bad   = 1'b0;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        fin_abort = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_en && (q_count != '0) && !cpl_vld && !acc_busy && !abort) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        ld_cfg    = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        rep_bad   = 1'b1;
                        state_nxt = S_REPORT;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY, S_WAIT_DONE: begin
                if (abort) begin
                    fin_abort = 1'b1;
                    state_nxt = S_DRAIN;
                end else if (tcnt == TIMEOUT) begin
                    fin_to    = 1'b1;
                    state_nxt = S_DRAIN;
                end else if ((state == S_WAIT_DONE) && acc_done) begin
                    fin_ok    = 1'b1;
                    state_nxt = S_REPORT;
                end else if ((state == S_WAIT_BUSY) && acc_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_DRAIN: begin
                if (!acc_busy) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (cpl_vld && cpl_rdy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_width, cmd_height, cmd_in_ch, cmd_out_ch,
                                       cmd_stride, cmd_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            q_count       <= '0;
            tcnt          <= '0;
            acc_width     <= '0;
            acc_height    <= '0;
            acc_in_ch     <= '0;
            acc_out_ch    <= '0;
            acc_stride    <= 4'd1;
            cpl_vld       <= 1'b0;
            cpl_tag       <= '0;
            cpl_last_addr <= '0;
            cpl_err       <= 2'b00;
        end else begin
            state   <= state_nxt;
            cpl_vld <= (state_nxt == S_REPORT);

            if (abort) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   q_count <= q_count + CW'(1);
                    2'b01:   q_count <= q_count - CW'(1);
                    default: q_count <= q_count;
                endcase
            end

            if (state == S_ISSUE) begin
                tcnt <= '0;
            end else if (((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && (tcnt != TIMEOUT)) begin
                tcnt <= tcnt + 20'd1;
            end

            if (pop) cpl_tag <= h_tag;
            if (ld_cfg) begin
                acc_width  <= h_width;
                acc_height <= h_height;
                acc_in_ch  <= h_in_ch;
                acc_out_ch <= h_out_ch;
                acc_stride <= h_stride;
            end

            if (rep_bad) begin
                cpl_err       <= 2'b01;
                cpl_last_addr <= '0;
            end else if (fin_ok || fin_to || fin_abort) begin
                cpl_err       <= fin_abort ? 2'b11 : (fin_to ? 2'b10 : 2'b00);
                cpl_last_addr <= acc_last_addr;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Self-checking bench for cnn_layer_seq: directed scenarios plus randomized descriptors
// against a queue-based reference model and a behavioural accelerator.
module tb_cnn_layer_seq;

    typedef struct {
        logic [7:0] w, h;
        logic [3:0] ic, oc, st, tag;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  cmd_width = '0, cmd_height = '0;
    logic [3:0]  cmd_in_ch = '0, cmd_out_ch = '0, cmd_stride = '0, cmd_tag = '0;
    logic        run_en = 1'b0, abort = 1'b0;
    logic        acc_start_vld;
    logic [7:0]  acc_width, acc_height;
    logic [3:0]  acc_in_ch, acc_out_ch, acc_stride;
    logic        acc_busy = 1'b0, acc_done = 1'b0;
    logic [11:0] acc_last_addr = '0;
    logic        cpl_vld;
    logic        cpl_rdy = 1'b0;
    logic [3:0]  cpl_tag;
    logic [11:0] cpl_last_addr;
    logic [1:0]  cpl_err;
    logic [2:0]  q_count;
    logic        seq_idle;

    cnn_layer_seq #(.DEPTH(4), .TIMEOUT(20'd100)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_in_ch(cmd_in_ch),
        .cmd_out_ch(cmd_out_ch), .cmd_stride(cmd_stride), .cmd_tag(cmd_tag),
        .run_en(run_en), .abort(abort), .acc_start_vld(acc_start_vld),
        .acc_width(acc_width), .acc_height(acc_height), .acc_in_ch(acc_in_ch),
        .acc_out_ch(acc_out_ch), .acc_stride(acc_stride), .acc_busy(acc_busy),
        .acc_done(acc_done), .acc_last_addr(acc_last_addr), .cpl_vld(cpl_vld),
        .cpl_rdy(cpl_rdy), .cpl_tag(cpl_tag), .cpl_last_addr(cpl_last_addr),
        .cpl_err(cpl_err), .q_count(q_count), .seq_idle(seq_idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    desc_t        exp_q[$];
    logic [27:0]  cfg_q[$];
    logic [11:0]  addr_q[$];

    // accelerator model controls and state
    int  n_starts = 0;
    int  done_lat = 41;
    int  busy_len = 150;
    bit  no_done_mode = 0;
    int  next_addr = -1;
    int  acc_ctr = 0, acc_end = 0;
    bit  acc_active = 0, acc_nodone = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                acc_active = 0;
            end else if (acc_start_vld) begin
                n_starts++;
                cfg_q.push_back({acc_width, acc_height, acc_in_ch, acc_out_ch, acc_stride});
                acc_last_addr = (next_addr >= 0) ? 12'(next_addr) : 12'($urandom_range(0, 4095));
                next_addr = -1;
                addr_q.push_back(acc_last_addr);
                acc_active = 1;
                acc_ctr    = 0;
                acc_nodone = no_done_mode;
                acc_end    = no_done_mode ? busy_len : done_lat;
            end else if (acc_active) begin
                acc_ctr++;
                if (abort && !acc_nodone) begin
                    acc_nodone = 1;
                    acc_end    = acc_ctr + 3;
                end
                if (acc_ctr > acc_end) acc_active = 0;
            end
            acc_busy = acc_active && (acc_ctr >= 1);
            acc_done = acc_active && !acc_nodone && (acc_ctr == acc_end);
        end
    end

    function automatic bit desc_ok(input desc_t d);
        return (d.st == 1 || d.st == 2) && d.ic >= 1 && d.ic <= 8 &&
               d.oc >= 1 && d.oc <= 8 && d.w >= 3 && d.h >= 3;
    endfunction

    function automatic desc_t rand_desc(input bit force_valid);
        desc_t d;
        d.tag = 4'($urandom_range(0, 15));
        if (force_valid) begin
            d.w  = 8'($urandom_range(3, 255));
            d.h  = 8'($urandom_range(3, 255));
            d.ic = 4'($urandom_range(1, 8));
            d.oc = 4'($urandom_range(1, 8));
            d.st = 4'($urandom_range(1, 2));
        end else begin
            d.w  = 8'($urandom_range(0, 12));
            d.h  = 8'($urandom_range(0, 12));
            d.ic = 4'($urandom_range(0, 10));
            d.oc = 4'($urandom_range(0, 10));
            d.st = 4'($urandom_range(0, 3));
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input desc_t d, input bit exp_rdy);
        cmd_width  = d.w;
        cmd_height = d.h;
        cmd_in_ch  = d.ic;
        cmd_out_ch = d.oc;
        cmd_stride = d.st;
        cmd_tag    = d.tag;
        cmd_vld    = 1'b1;
        chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, exp_rdy});
        tick();
        cmd_vld = 1'b0;
        if (exp_rdy) exp_q.push_back(d);
    endtask

    task automatic wait_cpl(input int bound);
        for (int i = 0; i < bound && cpl_vld !== 1'b1; i++) tick();
        chk("cpl_vld_seen", {31'd0, cpl_vld}, 32'd1);
    endtask

    // pops the next expected descriptor and checks its completion record
    task automatic expect_cpl(input int bound, input logic [1:0] ok_err, input bit chk_addr);
        desc_t       d;
        bit          v;
        logic [27:0] cfg;
        logic [11:0] a;
        d = exp_q.pop_front();
        v = desc_ok(d);
        wait_cpl(bound);
        chk("cpl_tag", {28'd0, cpl_tag}, {28'd0, d.tag});
        chk("cpl_err", {30'd0, cpl_err}, {30'd0, (v ? ok_err : 2'b01)});
        if (v) begin
            chk("layer_started", {31'd0, cfg_q.size() != 0}, 32'd1);
            if (cfg_q.size() != 0) begin
                cfg = cfg_q.pop_front();
                a   = addr_q.pop_front();
                chk("issued_cfg", {4'd0, cfg}, {4'd0, d.w, d.h, d.ic, d.oc, d.st});
                if (chk_addr) chk("cpl_last_addr", {20'd0, cpl_last_addr}, {20'd0, a});
            end
        end else begin
            chk("cpl_last_addr_bad", {20'd0, cpl_last_addr}, 32'd0);
        end
        cpl_rdy = 1'b1;
        tick();
        cpl_rdy = 1'b0;
        chk("cpl_vld_clear", {31'd0, cpl_vld}, 32'd0);
    endtask

    task automatic wait_busy(input int bound);
        for (int i = 0; i < bound && acc_busy !== 1'b1; i++) tick();
        chk("acc_busy_seen", {31'd0, acc_busy}, 32'd1);
    endtask

    initial begin
        desc_t d;
        int    base;
        logic [3:0]  h_tag;
        logic [11:0] h_addr;

        // reset state
        @(negedge clk);
        tick();
        tick();
        chk("rst_cmd_rdy",   {31'd0, cmd_rdy}, 32'd0);
        chk("rst_q_count",   {29'd0, q_count}, 32'd0);
        chk("rst_seq_idle",  {31'd0, seq_idle}, 32'd1);
        chk("rst_start",     {31'd0, acc_start_vld}, 32'd0);
        chk("rst_acc_cfg",   {4'd0, acc_width, acc_height, acc_in_ch, acc_out_ch, acc_stride},
                             32'h0000_0001);
        chk("rst_cpl",       {13'd0, cpl_vld, cpl_tag, cpl_last_addr, cpl_err}, 32'd0);
        rst = 1'b0;
        tick();
        chk("cmd_rdy_after_rst", {31'd0, cmd_rdy}, 32'd1);

        // single layer with fixed timing and address; start two edges after accept
        run_en    = 1'b1;
        next_addr = 3;
        d = '{w: 8'd10, h: 8'd10, ic: 4'd2, oc: 4'd1, st: 4'd1, tag: 4'd5};
        push(d, 1'b1);
        chk("start_n1", {31'd0, acc_start_vld}, 32'd0);
        tick();
        chk("start_n2", {31'd0, acc_start_vld}, 32'd1);
        tick();
        chk("start_n3", {31'd0, acc_start_vld}, 32'd0);
        expect_cpl(100, 2'b00, 1'b1);
        chk("single_starts", n_starts, 32'd1);

        // bad stride: reported quickly with no start
        d = '{w: 8'd10, h: 8'd10, ic: 4'd2, oc: 4'd1, st: 4'd3, tag: 4'd7};
        push(d, 1'b1);
        expect_cpl(3, 2'b00, 1'b1);
        chk("bad_no_start", n_starts, 32'd1);

        // fill queue with dispatch disabled, fifth refused, then drain in order
        run_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(rand_desc($urandom_range(0, 1) == 1), 1'b1);
            chk("fill_q_count", {29'd0, q_count}, 32'(i + 1));
        end
        push(rand_desc(1'b1), 1'b0);
        chk("full_q_count", {29'd0, q_count}, 32'd4);
        run_en = 1'b1;
        for (int i = 0; i < 4; i++) expect_cpl(200, 2'b00, 1'b1);
        chk("drained_idle", {31'd0, seq_idle}, 32'd1);

        // randomized single layers with random done latency
        for (int i = 0; i < 8; i++) begin
            done_lat = $urandom_range(2, 60);
            push(rand_desc($urandom_range(0, 1) == 1), 1'b1);
            expect_cpl(200, 2'b00, 1'b1);
        end

        // abort during WAIT_DONE with two more descriptors queued
        run_en = 1'b0;
        done_lat = 41;
        for (int i = 1; i <= 3; i++) begin
            d = rand_desc(1'b1);
            d.tag = 4'(i);
            push(d, 1'b1);
        end
        run_en = 1'b1;
        wait_busy(20);
        tick();
        tick();
        base  = n_starts;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_q_count", {29'd0, q_count}, 32'd0);
        expect_cpl(50, 2'b11, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_start", n_starts, base);
        chk("abort_idle", {31'd0, seq_idle}, 32'd1);

        // completion back-pressure with queue non-empty
        done_lat = $urandom_range(2, 30);
        push(rand_desc(1'b1), 1'b1);
        push(rand_desc(1'b1), 1'b1);
        wait_cpl(100);
        base   = n_starts;
        h_tag  = exp_q[0].tag;
        h_addr = (addr_q.size() != 0) ? addr_q[0] : 12'd0;
        for (int i = 0; i < 20; i++) begin
            chk("hold_fields", {14'd0, cpl_vld, cpl_tag, cpl_last_addr, cpl_err},
                {14'd0, 1'b1, h_tag, h_addr, 2'b00});
            tick();
        end
        chk("hold_no_start", n_starts, base);
        chk("hold_q_count", {29'd0, q_count}, 32'd1);
        expect_cpl(1, 2'b00, 1'b1);
        expect_cpl(200, 2'b00, 1'b1);

        // timeout: no done, busy held to cycle 150; report only after busy falls
        no_done_mode = 1;
        push(rand_desc(1'b1), 1'b1);
        for (int i = 0; i < 400 && cpl_vld !== 1'b1; i++) tick();
        chk("to_busy_fell", {31'd0, acc_busy}, 32'd0);
        chk("to_after_150", {31'd0, acc_ctr > 150}, 32'd1);
        expect_cpl(1, 2'b10, 1'b1);
        no_done_mode = 0;

        // reset mid-layer abandons the layer
        done_lat = 41;
        push(rand_desc(1'b1), 1'b1);
        wait_busy(20);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        cfg_q.delete();
        addr_q.delete();
        for (int i = 0; i < 10 && cpl_vld !== 1'b1; i++) tick();
        chk("rst_mid_no_cpl", {31'd0, cpl_vld}, 32'd0);
        chk("rst_mid_idle", {31'd0, seq_idle}, 32'd1);
        chk("rst_mid_stride", {28'd0, acc_stride}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_layer_seq.md
CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

Interface
REQ-001 Parameter DEPTH, default 4, descriptor FIFO depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 20'hFFFFF, maximum cycles allowed from issue to accelerator done.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port list (name / direction / width / meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- cmd_vld  in  1  descriptor offered
- cmd_rdy  out  1  FIFO can accept
- cmd_width, cmd_height  in  8 each  IFM dimensions
- cmd_in_ch, cmd_out_ch, cmd_stride  in  4 each  channels, stride
- cmd_tag  in  4  software tag
- run_en  in  1  dispatch enable
- abort  in  1  abort current layer, flush queue
- acc_start_vld  out  1  start pulse to accelerator
- acc_width, acc_height  out  8 each  issued config
- acc_in_ch, acc_out_ch, acc_stride  out  4 each  issued config
- acc_busy, acc_done  in  1 each  accelerator status
- acc_last_addr  in  12  accelerator last OFM block address
- cpl_vld  out  1  completion record valid
- cpl_rdy  in  1  completion accepted
- cpl_tag  out  4  tag of completed descriptor
- cpl_last_addr  out  12  captured acc_last_addr
- cpl_err  out  2  status: 00 ok, 01 bad config, 10 timeout, 11 aborted
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy
- seq_idle  out  1  state IDLE and q_count==0

Function
REQ-005 FIFO push: when cmd_vld && cmd_rdy; cmd_rdy = (q_count < DEPTH) && !rst; no bypass; a push and a pop in the same cycle leave q_count unchanged.
REQ-006 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DRAIN, REPORT.
REQ-007 IDLE with run_en=1, q_count>0, cpl_vld=0, acc_busy=0: check head entry; valid means stride in {1,2}, in_ch 1..8, out_ch 1..8, width>=3, height>=3.
REQ-008 Valid head: latch config into acc_* registers, latch tag, pop, go to ISSUE.
REQ-009 Invalid head: pop, go to REPORT with cpl_err=01 and cpl_last_addr=0; no start is issued.
REQ-010 ISSUE lasts exactly one cycle: acc_start_vld=1 and timeout counter cleared; then go to WAIT_BUSY.
REQ-011 acc_start_vld is 1 only in ISSUE, so it is a one-cycle pulse.
REQ-012 acc_* config outputs hold their value from issue until the next issue.
REQ-013 WAIT_BUSY: go to WAIT_DONE when acc_busy=1.
REQ-014 WAIT_DONE: on acc_done=1, capture acc_last_addr, set cpl_err=00, go to REPORT; acc_done is ignored in every other state.
REQ-015 Timeout counter increments every cycle in WAIT_BUSY and WAIT_DONE; when it reaches TIMEOUT, set cpl_err=10, capture acc_last_addr, go to DRAIN.
REQ-016 DRAIN: stay until acc_busy=0, then go to REPORT.
REQ-017 abort=1 in WAIT_BUSY or WAIT_DONE: set cpl_err=11, go to DRAIN.
REQ-018 abort=1 in any state clears the FIFO (q_count=0 next cycle; a same-cycle push is dropped, and cmd_rdy stays 1 as long as the FIFO is not full).
REQ-019 abort=1 in IDLE or ISSUE has no other effect; the layer already issued completes normally.
REQ-020 abort has priority over a same-cycle acc_done or timeout.
REQ-021 REPORT: set cpl_vld=1 with tag, last_addr and err stable; hold until cpl_vld && cpl_rdy, then clear cpl_vld the next cycle and return to IDLE.
REQ-022 Earliest cadence: cmd accepted at edge N; acc_start_vld high during cycle N+2.
REQ-023 run_en=0 blocks new dispatch only; an in-flight layer runs to completion.
REQ-024 Timeout counter is 20 bits and saturates at TIMEOUT (no wrap).
REQ-025 FIFO pointers wrap modulo DEPTH.

Reset
REQ-026 While rst=1 at a clock edge, the next state is:
- state IDLE, FIFO empty, q_count=0, cmd_rdy=0, seq_idle=1
- acc_start_vld=0, acc_width=0, acc_height=0, acc_in_ch=0, acc_out_ch=0, acc_stride=1
- cpl_vld=0, cpl_tag=0, cpl_last_addr=0, cpl_err=00, timeout counter=0
REQ-027 Reset mid-layer abandons the layer; no completion record is produced for it.

Verification
REQ-028 Push {w=10,h=10,in=2,out=1,stride=1,tag=5}, run_en=1, model asserts busy 1 cycle after start and done 40 cycles later with last_addr=12'h003 -> one start pulse; completion tag=5, last_addr=3, err=00.
REQ-029 Push 5 descriptors back-to-back with DEPTH=4, run_en=0 -> 5th refused (cmd_rdy=0, q_count=4); set run_en=1 -> four completions in push order.
REQ-030 Push stride=3, tag=7 -> no acc_start_vld; completion err=01, tag=7 within 3 cycles.
REQ-031 TIMEOUT=100, model never asserts done, busy drops at cycle 150 -> err=10 reported after busy falls, not before.
REQ-032 Three descriptors queued, abort during WAIT_DONE -> err=11 for the current tag, q_count=0, no further start.
REQ-033 Hold cpl_rdy=0 for 20 cycles with queue non-empty -> cpl fields stable, no new start until the handshake completes.
